// File: rtl/mode_counter.sv
// Up/down counter with prescaler, sync clear/load, wrap or saturate at the limits,
// terminal-count pulse, sticky overflow flag and compare pulse.

module mode_counter #(
    parameter int unsigned P_COUNT_W = 16,
    parameter int unsigned P_PRESC_W = 8,
    parameter int unsigned P_SAT     = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_dir,
    input  logic                 i_clr,
    input  logic                 i_load,
    input  logic [P_COUNT_W-1:0] i_load_val,
    input  logic [P_PRESC_W-1:0] i_presc,
    input  logic [P_COUNT_W-1:0] i_cmp_val,
    input  logic                 i_ovf_clr,
    output logic [P_COUNT_W-1:0] o_count,
    output logic                 o_tc,
    output logic                 o_ovf,
    output logic                 o_cmp_hit
);

    localparam logic [P_COUNT_W-1:0] CountMax  = '1;
    localparam logic [P_COUNT_W-1:0] CountZero = '0;
    localparam logic [P_COUNT_W-1:0] CountOne  = {{(P_COUNT_W-1){1'b0}}, 1'b1};
    localparam logic [P_PRESC_W-1:0] PrescOne  = {{(P_PRESC_W-1){1'b0}}, 1'b1};

    logic [P_COUNT_W-1:0] count_q, count_d;
    logic [P_PRESC_W-1:0] presc_q, presc_d;
    logic                 tc_q, tc_d;
    logic                 ovf_q, ovf_d;
    logic                 hit_q, hit_d;
    logic                 tick;

    always_comb begin
        count_d = count_q;
        presc_d = presc_q;
        tc_d    = 1'b0;
        hit_d   = 1'b0;
        tick    = 1'b0;

        if (i_clr) begin
            count_d = CountZero;
            presc_d = '0;
        end else if (i_load) begin
            count_d = i_load_val;
            presc_d = '0;
        end else if (i_en) begin
            // ">=" lets a reduced divider take effect without a long wrap-around
            if (presc_q >= i_presc) begin
                tick    = 1'b1;
                presc_d = '0;
            end else begin
                presc_d = presc_q + PrescOne;
            end
        end

        if (tick) begin
            if (i_dir) begin
                if (count_q == CountMax) begin
                    tc_d    = 1'b1;
                    count_d = (P_SAT != 0) ? CountMax : CountZero;
                end else begin
                    count_d = count_q + CountOne;
                end
            end else begin
                if (count_q == CountZero) begin
                    tc_d    = 1'b1;
                    count_d = (P_SAT != 0) ? CountZero : CountMax;
                end else begin
                    count_d = count_q - CountOne;
                end
            end
            hit_d = (count_d == i_cmp_val);
        end

        // Setting the flag wins over a simultaneous clear request
        if (tc_d) begin
            ovf_d = 1'b1;
        end else if (i_ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= CountZero;
            presc_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            presc_q <= presc_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            hit_q   <= hit_d;
        end
    end

    assign o_count   = count_q;
    assign o_tc      = tc_q;
    assign o_ovf     = ovf_q;
    assign o_cmp_hit = hit_q;

endmodule

// File: tb/tb_mode_counter.sv
// Scoreboard bench for mode_counter: one 16-bit wrapping instance and two 4-bit instances
// (wrap and saturate) share the control inputs; each scenario observes one of them.

module tb_mode_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, dir, clr, load, ovf_clr;
    logic [7:0]  presc;
    logic [15:0] lv16, cv16;
    logic [3:0]  lv4, cv4;

    logic [15:0] c16;
    logic [3:0]  c4w, c4s;
    logic        tc16, ovf16, hit16;
    logic        tc4w, ovf4w, hit4w;
    logic        tc4s, ovf4s, hit4s;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected {count[15:0], tc, ovf, cmp_hit}
    logic [18:0] sb[$];

    typedef struct {
        logic        en, dir, clr, load, oc;
        logic [7:0]  presc;
        logic [15:0] lv, cv;
        logic [18:0] exp;
    } step_t;

    always #5 clk = ~clk;

    mode_counter #(.P_COUNT_W(16), .P_PRESC_W(8), .P_SAT(0)) u16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_dir(dir), .i_clr(clr), .i_load(load),
        .i_load_val(lv16), .i_presc(presc), .i_cmp_val(cv16), .i_ovf_clr(ovf_clr),
        .o_count(c16), .o_tc(tc16), .o_ovf(ovf16), .o_cmp_hit(hit16)
    );

    mode_counter #(.P_COUNT_W(4), .P_PRESC_W(8), .P_SAT(0)) u4w (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_dir(dir), .i_clr(clr), .i_load(load),
        .i_load_val(lv4), .i_presc(presc), .i_cmp_val(cv4), .i_ovf_clr(ovf_clr),
        .o_count(c4w), .o_tc(tc4w), .o_ovf(ovf4w), .o_cmp_hit(hit4w)
    );

    mode_counter #(.P_COUNT_W(4), .P_PRESC_W(8), .P_SAT(1)) u4s (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_dir(dir), .i_clr(clr), .i_load(load),
        .i_load_val(lv4), .i_presc(presc), .i_cmp_val(cv4), .i_ovf_clr(ovf_clr),
        .o_count(c4s), .o_tc(tc4s), .o_ovf(ovf4s), .o_cmp_hit(hit4s)
    );

    function automatic logic [18:0] observe(int d);
        case (d)
            0:       return {c16, tc16, ovf16, hit16};
            1:       return {12'd0, c4w, tc4w, ovf4w, hit4w};
            default: return {12'd0, c4s, tc4s, ovf4s, hit4s};
        endcase
    endfunction

    function automatic step_t mk(bit e, bit d, bit c, bit l, bit oc, int p, int lv, int cv,
                                 int cnt, bit t, bit o, bit h);
        step_t s;
        logic [31:0] pv, lvv, cvv, cntv;
        pv = p; lvv = lv; cvv = cv; cntv = cnt;
        s.en = e; s.dir = d; s.clr = c; s.load = l; s.oc = oc;
        s.presc = pv[7:0]; s.lv = lvv[15:0]; s.cv = cvv[15:0];
        s.exp = {cntv[15:0], t, o, h};
        return s;
    endfunction

    task automatic drive(input step_t s);
        en = s.en; dir = s.dir; clr = s.clr; load = s.load; ovf_clr = s.oc;
        presc = s.presc; lv16 = s.lv; lv4 = s.lv[3:0]; cv16 = s.cv; cv4 = s.cv[3:0];
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_t q[$];
        logic [18:0] o, e;
        cycle();
        sb.push_back(19'h0);
        o = observe(0); e = sb.pop_front(); n_checks++;
        if (o !== e) $display("FAIL reset_hold: got %h expected %h", o, e);
        else n_pass++;
        #2 rst_n = 1'b1;
        q.push_back(mk(0, 1, 0, 1, 0, 0, 'hFFFF, 'h8000, 'hFFFF, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 0, 0, 0, 'hFFFF, 'h8000, 'h0000, 1, 1, 0));
        q.push_back(mk(0, 1, 0, 1, 0, 0, 'h1234, 'h8000, 'h1234, 0, 1, 0));
        foreach (q[i]) begin
            drive(q[i]);
            sb.push_back(q[i].exp);
            cycle();
            o = observe(0); e = sb.pop_front(); n_checks++;
            if (o !== e) $display("FAIL reset_seq[%0d]: got %h expected %h", i, o, e);
            else n_pass++;
        end
        load = 1'b0;
        #2 rst_n = 1'b0;
        sb.push_back(19'h0);
        #1;
        o = observe(0); e = sb.pop_front(); n_checks++;
        if (o !== e) $display("FAIL reset_async: got %h expected %h", o, e);
        else n_pass++;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        step_t q[$];
        logic [18:0] o, e;
        q.push_back(mk(0, 1, 0, 1, 1, 0, 14, 9, 14, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 0, 0, 0, 14, 9, 15, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 0, 0, 0, 14, 9, 0, 1, 1, 0));
        q.push_back(mk(1, 1, 0, 0, 0, 0, 14, 9, 1, 0, 1, 0));
        q.push_back(mk(0, 1, 0, 0, 1, 0, 14, 9, 1, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 9, 0, 0, 0, 0));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 9, 15, 1, 1, 0));
        foreach (q[i]) begin
            drive(q[i]);
            sb.push_back(q[i].exp);
            cycle();
            o = observe(1); e = sb.pop_front(); n_checks++;
            if (o !== e) $display("FAIL wrap[%0d]: got %h expected %h", i, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_saturate();
        step_t q[$];
        logic [18:0] o, e;
        q.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        q.push_back(mk(0, 1, 0, 1, 1, 0, 14, 15, 14, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 0, 0, 0, 14, 15, 15, 0, 0, 1));
        q.push_back(mk(1, 1, 0, 0, 0, 0, 14, 15, 15, 1, 1, 1));
        q.push_back(mk(1, 0, 0, 0, 0, 0, 14, 15, 14, 0, 1, 0));
        foreach (q[i]) begin
            drive(q[i]);
            sb.push_back(q[i].exp);
            cycle();
            o = observe(2); e = sb.pop_front(); n_checks++;
            if (o !== e) $display("FAIL saturate[%0d]: got %h expected %h", i, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_prescaler();
        step_t q[$];
        logic [18:0] o, e;
        int cnt_seq[14] = '{'h100, 'h100, 'h100, 'h101, 'h101, 'h101, 'h101, 'h102,
                            'h102, 'h102, 'h102, 'h102, 'h102, 'h103};
        bit en_seq[14]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1};
        q.push_back(mk(0, 1, 0, 1, 1, 3, 'h100, 'hFFFF, 'h100, 0, 0, 0));
        for (int k = 0; k < 14; k++)
            q.push_back(mk(en_seq[k], 1, 0, 0, 0, 3, 'h100, 'hFFFF, cnt_seq[k], 0, 0, 0));
        q.push_back(mk(0, 1, 0, 1, 0, 10, 'h200, 'hFFFF, 'h200, 0, 0, 0));
        for (int k = 0; k < 4; k++)
            q.push_back(mk(1, 1, 0, 0, 0, 10, 'h200, 'hFFFF, 'h200, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 0, 0, 2, 'h200, 'hFFFF, 'h201, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 0, 0, 2, 'h200, 'hFFFF, 'h201, 0, 0, 0));
        foreach (q[i]) begin
            drive(q[i]);
            sb.push_back(q[i].exp);
            cycle();
            o = observe(0); e = sb.pop_front(); n_checks++;
            if (o !== e) $display("FAIL prescaler[%0d]: got %h expected %h", i, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_clr_load();
        step_t q[$];
        logic [18:0] o, e;
        q.push_back(mk(1, 1, 1, 1, 0, 0, 'hAA, 'hAA, 0, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 1, 0, 0, 'hAA, 'hAA, 'hAA, 0, 0, 0));
        q.push_back(mk(0, 1, 0, 0, 0, 0, 'hAA, 'hAA, 'hAA, 0, 0, 0));
        q.push_back(mk(0, 1, 1, 0, 0, 0, 'hAA, 'hAA, 0, 0, 0, 0));
        foreach (q[i]) begin
            drive(q[i]);
            sb.push_back(q[i].exp);
            cycle();
            o = observe(0); e = sb.pop_front(); n_checks++;
            if (o !== e) $display("FAIL clr_load[%0d]: got %h expected %h", i, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_cmp();
        step_t q[$];
        logic [18:0] o, e;
        q.push_back(mk(0, 1, 0, 1, 0, 0, 3, 5, 3, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 0, 0, 0, 3, 5, 4, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 0, 0, 0, 3, 5, 5, 0, 0, 1));
        q.push_back(mk(1, 1, 0, 0, 0, 0, 3, 5, 6, 0, 0, 0));
        q.push_back(mk(0, 1, 0, 0, 0, 0, 3, 5, 6, 0, 0, 0));
        foreach (q[i]) begin
            drive(q[i]);
            sb.push_back(q[i].exp);
            cycle();
            o = observe(0); e = sb.pop_front(); n_checks++;
            if (o !== e) $display("FAIL cmp[%0d]: got %h expected %h", i, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_ovf_priority();
        step_t q[$];
        logic [18:0] o, e;
        q.push_back(mk(0, 1, 0, 1, 1, 0, 15, 9, 15, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 0, 1, 0, 15, 9, 0, 1, 1, 0));
        q.push_back(mk(0, 1, 0, 0, 1, 0, 15, 9, 0, 0, 0, 0));
        foreach (q[i]) begin
            drive(q[i]);
            sb.push_back(q[i].exp);
            cycle();
            o = observe(1); e = sb.pop_front(); n_checks++;
            if (o !== e) $display("FAIL ovf_priority[%0d]: got %h expected %h", i, o, e);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; dir = 1'b1; clr = 1'b0; load = 1'b0; ovf_clr = 1'b0;
        presc = '0; lv16 = '0; cv16 = '0; lv4 = '0; cv4 = '0;
        test_reset();
        test_wrap();
        test_saturate();
        test_prescaler();
        test_clr_load();
        test_cmp();
        test_ovf_priority();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
